uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between N_REQ requesters. Arbitrates round-robin and can hold the grant for multi-byte packets. Sequences each byte into the UART: start pulse, then wait for busy, then wait for free. Reads UART status (busy, free) from the UART side of the register interface and flags a stalled transmitter through a timeout.

---
 rtl/uart_tx_scheduler.sv | 124 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ requesters,
// with multi-byte packet lock, per-byte start/busy/free sequencing and busy timeout.
module uart_tx_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      uart_busy,
  input  logic                      uart_free,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      locked,
  output logic                      sched_busy,
  output logic                      err_timeout
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_FREE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_REQ-1:0]    eligible;
  logic [IDX_W-1:0]    winner;
  logic                found;
  logic                accept;
  logic                cnt_hit;
  logic                timeout_hit;
  logic [DATA_W-1:0]   win_data;
  int unsigned         idx;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    return IDX_W'((32'(i) + 32'd1) % N_REQ);
  endfunction

  // Arbitration: first eligible requester at or after rr_ptr, lock restricts to owner
  always_comb begin
    eligible = locked ? (req_valid & (N_REQ'(1) << grant_id)) : req_valid;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!found && eligible[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    accept   = (state_q == IDLE) && uart_free && found;
    win_data = req_data[32'(winner)*DATA_W +: DATA_W];
    cnt_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_busy)    state_d = WAIT_FREE;
        else if (cnt_hit) state_d = IDLE;
      end
      WAIT_FREE: if (!uart_busy && uart_free) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode: ready is only ever offered to the winner while idle
  always_comb begin
    req_ready   = '0;
    timeout_hit = 1'b0;
    sched_busy  = (state_q != IDLE);
    if (accept) req_ready = N_REQ'(1) << winner;
    if (state_q == WAIT_BUSY && !uart_busy && cnt_hit) timeout_hit = 1'b1;
  end

  // Registered datapath: byte latch, grant, lock, pointer, timeout counter and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      locked      <= 1'b0;
      grant_id    <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      cnt_q       <= '0;
    end else begin
      tx_start    <= accept;
      err_timeout <= timeout_hit;
      if (accept) begin
        tx_data  <= win_data;
        grant_id <= winner;
        locked   <= ~req_last[winner];
        if (req_last[winner]) rr_ptr <= inc_wrap(winner);
      end
      if (state_q == START) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_BUSY && !uart_busy && !cnt_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_hit) begin
        locked <= 1'b0;
        rr_ptr <= inc_wrap(grant_id);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (N_REQ=4, DATA_W=8, TIMEOUT=16).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        uart_busy;
  logic        uart_free;
  logic [1:0]  grant_id;
  logic        locked;
  logic        sched_busy;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  uart_tx_scheduler #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data),
    .uart_busy(uart_busy), .uart_free(uart_free),
    .grant_id(grant_id), .locked(locked),
    .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"},    32'(tx_start),    32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
    check({tag, "_locked"},      32'(locked),      32'd0);
    check({tag, "_sched_busy"},  32'(sched_busy),  32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full byte transfer; caller has already driven valid/last/data in IDLE
  task automatic do_byte(input string tag, input logic [3:0] exp_ready, input logic [1:0] exp_gid,
                         input logic [7:0] exp_data, input logic exp_locked, input int busy_n);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    tick();
    check({tag, "_start"},  32'(tx_start), 32'd1);
    check({tag, "_gid"},    32'(grant_id), 32'(exp_gid));
    check({tag, "_data"},   32'(tx_data),  32'(exp_data));
    check({tag, "_locked"}, 32'(locked),   32'(exp_locked));
    check({tag, "_noready"}, 32'(req_ready), 32'd0);
    uart_free = 1'b0;
    uart_busy = 1'b1;
    tick();
    check({tag, "_start_off"}, 32'(tx_start), 32'd0);
    tick();
    repeat (busy_n - 1) tick();
    uart_busy = 1'b0;
    uart_free = 1'b1;
    tick();
    check({tag, "_idle"}, 32'(sched_busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'h0;
    req_last  = 4'h0;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    uart_busy = 1'b0;
    uart_free = 1'b1;

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single byte from requester 2
    req_valid = 4'b0100;
    req_last  = 4'hF;
    req_data  = {8'hD3, 8'hA5, 8'hB1, 8'hA0};
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    check("single_start", 32'(tx_start), 32'd1);
    check("single_data",  32'(tx_data),  32'hA5);
    check("single_gid",   32'(grant_id), 32'd2);
    req_valid = 4'h0;
    uart_free = 1'b0;
    uart_busy = 1'b1;
    tick();
    tick();
    uart_free = 1'b1;
    tick();
    check("free_and_busy_holds", 32'(sched_busy), 32'd1);
    uart_busy = 1'b0;
    tick();
    check("single_idle", 32'(sched_busy), 32'd0);
    check("single_hold_data", 32'(tx_data), 32'hA5);
    req_valid = 4'hF;
    #1;
    check("single_rr_ptr3", 32'(req_ready), 32'h8);
    req_valid = 4'h0;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // Round-robin fairness from a fresh pointer
    sync_reset();
    req_valid = 4'hF;
    req_last  = 4'hF;
    do_byte("rr0", 4'b0001, 2'd0, 8'hA0, 1'b0, 5);
    do_byte("rr1", 4'b0010, 2'd1, 8'hB1, 1'b0, 5);
    do_byte("rr2", 4'b0100, 2'd2, 8'hC2, 1'b0, 5);
    do_byte("rr3", 4'b1000, 2'd3, 8'hD3, 1'b0, 5);
    do_byte("rr4", 4'b0001, 2'd0, 8'hA0, 1'b0, 5);

    // Packet lock: req0 sends three bytes while req1 waits
    req_valid = 4'h0;
    sync_reset();
    req_valid = 4'b0011;
    req_last  = 4'b0010;
    do_byte("lock_b0", 4'b0001, 2'd0, 8'hA0, 1'b1, 2);
    do_byte("lock_b1", 4'b0001, 2'd0, 8'hA0, 1'b1, 2);
    req_last  = 4'b0011;
    do_byte("lock_b2", 4'b0001, 2'd0, 8'hA0, 1'b0, 2);
    do_byte("lock_next", 4'b0010, 2'd1, 8'hB1, 1'b0, 2);

    // Timeout: pointer is 2, req0 wins by wrap and opens a lock
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    #1;
    check("to_ready", 32'(req_ready), 32'h1);
    tick();
    check("to_start",  32'(tx_start), 32'd1);
    check("to_locked", 32'(locked),   32'd1);
    req_valid = 4'h0;
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("to_quiet", 32'(err_timeout), 32'd0);
    end
    tick();
    check("to_pulse",    32'(err_timeout), 32'd1);
    check("to_unlock",   32'(locked),      32'd0);
    check("to_idle",     32'(sched_busy),  32'd0);
    tick();
    check("to_pulse_end", 32'(err_timeout), 32'd0);
    req_valid = 4'b1011;
    #1;
    check("to_rr_ptr1", 32'(req_ready), 32'h2);
    req_valid = 4'h0;

    // Backpressure: UART not free
    uart_free = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
      check("bp_start", 32'(tx_start), 32'd0);
    end
    uart_free = 1'b1;
    do_byte("bp_accept", 4'b0010, 2'd1, 8'hB1, 1'b0, 2);

    // Async reset while locked in WAIT_FREE
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    #1;
    check("ar_ready", 32'(req_ready), 32'h4);
    tick();
    check("ar_locked", 32'(locked), 32'd1);
    req_valid = 4'h0;
    uart_free = 1'b0;
    uart_busy = 1'b1;
    tick();
    tick();
    check("ar_in_wait_free", 32'(sched_busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #2;
    rst = 1'b0;
    uart_busy = 1'b0;
    uart_free = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ar_no_start", 32'(tx_start), 32'd0);
    end
    req_valid = 4'b0001;
    req_last  = 4'hF;
    do_byte("ar_after", 4'b0001, 2'd0, 8'hA0, 1'b0, 1);
    req_valid = 4'h0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
